alu_cmd_sequencer: RTL and testbench

Command-issuing front end that drives the 4-bit ALU, which is a combinational executor with A, B, opcode inputs and X, Y outputs. It accepts one operation command per valid/ready handshake and registers the operands and opcode onto the ALU inputs. After a settle interval it captures {Y,X}, qualifies the result (Y masking, error flag) and presents it on a valid/ready response port. The sequencer is non-pipelined: exactly one command is in flight at a time.

---
 rtl/alu_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit combinational ALU: one command in flight, settle, capture, respond.
// Optional build macro ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_carry outputs.
`timescale 1ns/1ps
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [3:0]       alu_x,
    input  logic [3:0]       alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_x,
    output logic [3:0]       rsp_y,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic             rsp_zero,
    output logic             rsp_carry
`endif
);

    localparam int unsigned NIB_W       = 4;
    localparam logic [NIB_W-1:0] OP_ADD     = 4'b0111;
    localparam logic [NIB_W-1:0] OP_SUB     = 4'b1000;
    localparam logic [NIB_W-1:0] OP_DIV     = 4'b1010;
    localparam logic [NIB_W-1:0] OP_IDLE    = 4'b1111;
    localparam logic [NIB_W-1:0] SETTLE_LD  = NIB_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t             state_q;
    logic [NIB_W-1:0]   settle_q;
    logic [NIB_W-1:0]   alu_a_q, alu_b_q, alu_op_q;
    logic [NIB_W-1:0]   rsp_x_q, rsp_y_q;
    logic               rsp_valid_q, rsp_err_q;
    logic [CNT_W-1:0]   cnt_q;

    // Result qualification applied at the capture edge
    logic               div_zero;
    logic [NIB_W-1:0]   cap_x, cap_y;
    assign div_zero = (alu_op_q == OP_DIV) && (alu_b_q == '0);
    assign cap_x    = div_zero ? '0 : alu_x;
    assign cap_y    = (div_zero || (alu_op_q < OP_ADD)) ? '0 : alu_y;

`ifdef ALU_SEQ_FLAGS_EN
    logic rsp_zero_q, rsp_carry_q;
    logic cap_carry;
    assign cap_carry = ((alu_op_q == OP_ADD) && alu_y[0]) || ((alu_op_q == OP_SUB) && alu_y[3]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_IDLE;
            rsp_x_q     <= '0;
            rsp_y_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
`ifdef ALU_SEQ_FLAGS_EN
            rsp_zero_q  <= 1'b0;
            rsp_carry_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op <= OP_DIV) begin
                            alu_a_q  <= cmd_a;
                            alu_b_q  <= cmd_b;
                            alu_op_q <= cmd_op;
                            settle_q <= SETTLE_LD;
                            state_q  <= ISSUE;
                        end else begin
                            // Illegal opcode: skip the ALU entirely and report an error
                            rsp_x_q     <= '0;
                            rsp_y_q     <= '0;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                            rsp_zero_q  <= 1'b0;
                            rsp_carry_q <= 1'b0;
`endif
                            state_q     <= RESPOND;
                        end
                    end
                end
                ISSUE: begin
                    if (settle_q == '0) begin
                        rsp_x_q     <= cap_x;
                        rsp_y_q     <= cap_y;
                        rsp_err_q   <= div_zero;
                        rsp_valid_q <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
                        rsp_zero_q  <= ({cap_y, cap_x} == '0) && !div_zero;
                        rsp_carry_q <= cap_carry && !div_zero;
`endif
                        state_q     <= RESPOND;
                    end else begin
                        settle_q <= settle_q - NIB_W'(1);
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_x      = rsp_x_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_err    = rsp_err_q;
    assign cmd_count  = cnt_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 and 3) driving a behavioural ALU, checked against a reference model.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [1:0][3:0]  cmd_op, cmd_a, cmd_b, alu_a, alu_b, alu_opcode, rsp_x, rsp_y;
    logic [1:0][7:0]  alu_xy, cmd_count;
`ifdef ALU_SEQ_FLAGS_EN
    logic [1:0]       rsp_zero, rsp_carry;
`endif

    int checks = 0;
    int passed = 0;
    logic [7:0] exp_cnt [2];
    logic [3:0] last_op [2];

    // Behavioural ALU: {Y,X}; logic ops drive junk on Y so masking is exercised
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'd0:    return {4'hF, a & b};
            4'd1:    return {4'hF, a | b};
            4'd2:    return {4'hF, ~(a & b)};
            4'd3:    return {4'hF, ~(a | b)};
            4'd4:    return {4'hF, a ^ b};
            4'd5:    return {4'hF, ~(a ^ b)};
            4'd6:    return {4'hF, ~a};
            4'd7:    return {4'h0, a} + {4'h0, b};
            4'd8:    return {4'h0, a} - {4'h0, b};
            4'd9:    return {4'h0, a} * {4'h0, b};
            4'd10:   return (b == 4'h0) ? 8'h00 : {a % b, a / b};
            default: return 8'h00;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        assign alu_xy[g] = alu_model(alu_opcode[g], alu_a[g], alu_b[g]);
        alu_cmd_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 3), .CNT_W(8)) dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .cmd_valid  (cmd_valid[g]),
            .cmd_ready  (cmd_ready[g]),
            .cmd_op     (cmd_op[g]),
            .cmd_a      (cmd_a[g]),
            .cmd_b      (cmd_b[g]),
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_opcode (alu_opcode[g]),
            .alu_x      (alu_xy[g][3:0]),
            .alu_y      (alu_xy[g][7:4]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_x      (rsp_x[g]),
            .rsp_y      (rsp_y[g]),
            .rsp_err    (rsp_err[g]),
            .busy       (busy[g]),
            .cmd_count  (cmd_count[g])
`ifdef ALU_SEQ_FLAGS_EN
            ,
            .rsp_zero   (rsp_zero[g]),
            .rsp_carry  (rsp_carry[g])
`endif
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input int n, input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready[n]), 32'd1);
        chk({tag, "_busy"},      32'(busy[n]), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid[n]), 32'd0);
        chk({tag, "_alu_op"},    32'(alu_opcode[n]), 32'hF);
        chk({tag, "_alu_ab"},    32'({alu_a[n], alu_b[n]}), 32'h0);
        chk({tag, "_rsp"},       32'({rsp_x[n], rsp_y[n], rsp_err[n]}), 32'h0);
        chk({tag, "_count"},     32'(cmd_count[n]), 32'h0);
    endtask

    // One complete transaction with the response withheld for 'hold' cycles
    task automatic run_cmd(input int n, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input int hold, output logic [3:0] ox, output logic [3:0] oy, output logic oerr);
        logic       legal;
        logic [7:0] res;
        logic [3:0] ex, ey;
        logic       eerr, ezero, ecarry;
        int         lat;
        int         settle;
        settle = (n == 0) ? 1 : 3;
        legal  = (op <= 4'd10);
        res    = alu_model(op, a, b);
        eerr   = !legal || (op == 4'd10 && b == 4'h0);
        ex     = eerr ? 4'h0 : res[3:0];
        ey     = (eerr || op < 4'd7) ? 4'h0 : res[7:4];
        ezero  = ({ey, ex} == 8'h00) && !eerr;
        ecarry = !eerr && ((op == 4'd7 && res[4]) || (op == 4'd8 && res[7]));

        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready[n]), 32'd1);
        cmd_valid[n] = 1'b1;
        cmd_op[n] = op; cmd_a[n] = a; cmd_b[n] = b;
        @(posedge clk);
        @(negedge clk);
        cmd_op[n] = 4'($urandom); cmd_a[n] = 4'($urandom); cmd_b[n] = 4'($urandom);
        lat = 0;
        while (!rsp_valid[n] && lat < 20) begin
            chk("issue_busy",      32'(busy[n]), 32'd1);
            chk("issue_cmd_ready", 32'(cmd_ready[n]), 32'd0);
            chk("issue_alu_hold",  32'({alu_opcode[n], alu_a[n], alu_b[n]}), 32'({op, a, b}));
            @(negedge clk);
            lat++;
            cmd_op[n] = 4'($urandom); cmd_a[n] = 4'($urandom); cmd_b[n] = 4'($urandom);
        end
        chk("latency", 32'(lat), legal ? 32'(settle) : 32'd0);
        chk("rsp_x",   32'(rsp_x[n]), 32'(ex));
        chk("rsp_y",   32'(rsp_y[n]), 32'(ey));
        chk("rsp_err", 32'(rsp_err[n]), 32'(eerr));
        if (legal) last_op[n] = op;
        chk("alu_opcode_after", 32'(alu_opcode[n]), 32'(last_op[n]));
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero",  32'(rsp_zero[n]), 32'(ezero));
        chk("rsp_carry", 32'(rsp_carry[n]), 32'(ecarry));
`endif
        ox = rsp_x[n]; oy = rsp_y[n]; oerr = rsp_err[n];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            cmd_op[n] = 4'($urandom); cmd_a[n] = 4'($urandom); cmd_b[n] = 4'($urandom);
            chk("hold_valid",     32'(rsp_valid[n]), 32'd1);
            chk("hold_busy",      32'(busy[n]), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready[n]), 32'd0);
            chk("hold_rsp",       32'({rsp_x[n], rsp_y[n], rsp_err[n]}), 32'({ex, ey, eerr}));
        end
        cmd_valid[n] = 1'b0;
        rsp_ready[n] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[n] = 1'b0;
        exp_cnt[n] = exp_cnt[n] + 8'd1;
        chk("post_rsp_valid", 32'(rsp_valid[n]), 32'd0);
        chk("post_cmd_ready", 32'(cmd_ready[n]), 32'd1);
        chk("post_count",     32'(cmd_count[n]), 32'(exp_cnt[n]));
    endtask

    task automatic run_random(input int n, input int num, input int max_hold);
        logic [3:0] op, a, b, ox, oy;
        logic       oerr;
        for (int i = 0; i < num; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
            a  = 4'($urandom);
            b  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
            run_cmd(n, op, a, b, $urandom_range(0, max_hold), ox, oy, oerr);
        end
    endtask

    initial begin
        logic [3:0] ox, oy;
        logic       oerr;
        logic [7:0] cnt_before;
        rst_n = 2'b00; cmd_valid = 2'b00; rsp_ready = 2'b00;
        cmd_op = '0; cmd_a = '0; cmd_b = '0;
        for (int n = 0; n < 2; n++) begin
            exp_cnt[n] = 8'h00;
            last_op[n] = 4'hF;
        end
        repeat (3) @(negedge clk);
        chk_reset_state(0, "rst0");
        chk_reset_state(1, "rst1");
        rst_n = 2'b11;
        @(negedge clk);

        run_cmd(0, 4'd0, 4'hC, 4'hA, 0, ox, oy, oerr);
        chk("tp_and", 32'({ox, oy, oerr}), 32'({4'h8, 4'h0, 1'b0}));
        chk("tp_and_count", 32'(cmd_count[0]), 32'd1);
        run_cmd(0, 4'd7, 4'hF, 4'h1, 1, ox, oy, oerr);
        chk("tp_add", 32'({ox, oy, oerr}), 32'({4'h0, 4'h1, 1'b0}));
        run_cmd(0, 4'd8, 4'h3, 4'h5, 0, ox, oy, oerr);
        chk("tp_sub", 32'({ox, oy, oerr}), 32'({4'hE, 4'hF, 1'b0}));
        run_cmd(0, 4'd9, 4'hF, 4'hF, 0, ox, oy, oerr);
        chk("tp_mul", 32'({ox, oy, oerr}), 32'({4'h1, 4'hE, 1'b0}));
        run_cmd(0, 4'd10, 4'hD, 4'h4, 0, ox, oy, oerr);
        chk("tp_div", 32'({ox, oy, oerr}), 32'({4'h3, 4'h1, 1'b0}));
        run_cmd(0, 4'd10, 4'h9, 4'h0, 0, ox, oy, oerr);
        chk("tp_div0", 32'({ox, oy, oerr}), 32'({4'h0, 4'h0, 1'b1}));
        run_cmd(0, 4'hC, 4'h7, 4'h7, 2, ox, oy, oerr);
        chk("tp_illegal", 32'({ox, oy, oerr}), 32'({4'h0, 4'h0, 1'b1}));
        chk("tp_illegal_aluop", 32'(alu_opcode[0]), 32'hA);

        run_cmd(1, 4'd4, 4'h5, 4'hF, 5, ox, oy, oerr);
        chk("tp_xor_settle3", 32'({ox, oy, oerr}), 32'({4'hA, 4'h0, 1'b0}));

        run_random(0, 40, 3);
        run_random(1, 40, 3);

        // Asynchronous reset while a command is settling
        @(negedge clk);
        cmd_valid[1] = 1'b1; cmd_op[1] = 4'd4; cmd_a[1] = 4'h3; cmd_b[1] = 4'h6;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        chk("pre_reset_busy", 32'(busy[1]), 32'd1);
        #2 rst_n[1] = 1'b0;
        #1 chk_reset_state(1, "midreset");
        exp_cnt[1] = 8'h00;
        last_op[1] = 4'hF;
        @(negedge clk);
        rst_n[1] = 1'b1;
        run_random(1, 10, 2);

        // Counter wraps modulo 256
        cnt_before = exp_cnt[0];
        run_random(0, 256, 0);
        chk("count_wrap", 32'(cmd_count[0]), 32'(cnt_before));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
